// File: rtl/vga_scan_reader_if.sv
// VRAM read port plus VGA pin bundle for the scan-out reader.
// master = the reader (drives the address and the pins), slave = VRAM/pin side.
interface vga_scan_reader_if;
  logic [14:0] raddr;        // VRAM read address
  logic [11:0] rdata;        // VRAM read data, valid a fixed latency after raddr
  logic [11:0] rgb;          // {R[3:0],G[3:0],B[3:0]}
  logic        hs;           // horizontal sync (pin level)
  logic        vs;           // vertical sync (pin level)
  logic        de;           // rgb carries a visible pixel
  logic        frame_start;  // one-clock pulse with output pixel (0,0)

  modport master (
    output raddr,
    input  rdata,
    output rgb, hs, vs, de, frame_start
  );

  modport slave (
    input  raddr,
    output rdata,
    input  rgb, hs, vs, de, frame_start
  );
endinterface

// File: rtl/vga_scan_reader.sv
// Display-side reader of the 200x150x12b frame buffer.
// Generates 800x600@72Hz timing from a 50 MHz pixel clock, fetches one VRAM
// word per 4x4 screen block and re-aligns sync/enable with the read latency.
module vga_scan_reader #(
  parameter int H_VIS    = 800,
  parameter int H_FP     = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BP     = 64,
  parameter int V_VIS    = 600,
  parameter int V_FP     = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 23,
  parameter int SCALE_SH = 2,
  parameter int IMG_W    = 200,
  parameter int RD_LAT   = 1,      // 1..3
  parameter bit SYNC_POL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  vga_scan_reader_if.master bus
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  // Counters at cycle t reach the pins at t+DEPTH: address reg, VRAM, rgb reg.
  localparam int DEPTH = 2 + RD_LAT;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_VIS_L  = HW'(H_VIS);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_VIS_L  = VW'(V_VIS);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [14:0]   IMG_W_L  = 15'(IMG_W);

  // Control bits travelling alongside the pixel, stored as "active" flags.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic fs;
  } ctl_t;

  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;
  logic [14:0]   r_raddr;
  logic [11:0]   r_rgb;
  ctl_t          r_pipe [DEPTH];

  logic          w_vis;
  logic [HW-1:0] w_col;
  logic [VW-1:0] w_row;
  logic [14:0]   w_addr;
  ctl_t          w_ctl;

  // Row base address as a shift-add over the set bits of the row pitch.
  function automatic logic [14:0] row_base(input logic [VW-1:0] row);
    logic [14:0] acc;
    acc = '0;
    for (int b = 0; b < 15; b++) begin
      if (IMG_W_L[b]) acc = acc + (15'(row) << b);
    end
    return acc;
  endfunction

  assign w_vis  = (r_hcnt < H_VIS_L) && (r_vcnt < V_VIS_L);
  assign w_col  = r_hcnt >> SCALE_SH;
  assign w_row  = r_vcnt >> SCALE_SH;
  assign w_addr = row_base(w_row) + 15'(w_col);

  assign w_ctl.hs = (r_hcnt >= HS_BEG) && (r_hcnt <= HS_END);
  assign w_ctl.vs = (r_vcnt >= VS_BEG) && (r_vcnt <= VS_END);
  assign w_ctl.de = w_vis;
  assign w_ctl.fs = (r_hcnt == '0) && (r_vcnt == '0);

  // Raster position: hcnt every clock, vcnt on hcnt wrap.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement or block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (r_hcnt == H_LAST) begin
      r_hcnt <= '0;
      r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + VW'(1);
    end else begin
      r_hcnt <= r_hcnt + HW'(1);
    end
  end

  // Registered VRAM address; parked at 0 outside the visible window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_raddr <= '0;
    end else begin
      r_raddr <= w_vis ? w_addr : 15'd0;
    end
  end

  // Delay line for syncs/enable and the final rgb register, blanked when de=0.
  // NOTE: this delay line is a handful of flops, not a RAM, so it is cleared
  // on reset; that is what keeps a mid-frame reset from leaking a sync pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
      r_rgb <= '0;
    end else begin
      r_pipe[0] <= w_ctl;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
      // rdata arrives in the same cycle its control bits sit in stage DEPTH-2.
      r_rgb <= r_pipe[DEPTH-2].de ? bus.rdata : 12'h000;
    end
  end

  assign bus.raddr       = r_raddr;
  assign bus.rgb         = r_rgb;
  assign bus.de          = r_pipe[DEPTH-1].de;
  assign bus.frame_start = r_pipe[DEPTH-1].fs;
  assign bus.hs          = r_pipe[DEPTH-1].hs ? SYNC_POL : ~SYNC_POL;
  assign bus.vs          = r_pipe[DEPTH-1].vs ? SYNC_POL : ~SYNC_POL;

endmodule

// File: tb/tb_vga_scan_reader.sv
// Directed bench for vga_scan_reader: full horizontal timing, a short vertical
// timing (10 visible lines) to keep frames cheap, and two instances sharing
// one VRAM model, one with read latency 1 and one with read latency 2.
module tb_vga_scan_reader;

  localparam int H_TOT  = 1040;
  localparam int V_VIS  = 10;
  localparam int V_FP   = 1;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 1;
  localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;  // 14
  localparam int FRAME  = H_TOT * V_TOT;                 // 14560

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  vga_scan_reader_if bus1 ();
  vga_scan_reader_if bus2 ();

  vga_scan_reader #(
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .RD_LAT(1)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.master)
  );

  vga_scan_reader #(
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .RD_LAT(2)
  ) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.master)
  );

  // VRAM model: registered read, one port per instance with its own latency.
  logic [11:0] mem [0:32767];
  logic [11:0] rd2_q;

  always_ff @(posedge clk) bus1.rdata <= mem[bus1.raddr];

  always_ff @(posedge clk) begin
    rd2_q      <= mem[bus2.raddr];
    bus2.rdata <= rd2_q;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int pos      = 0;   // clocks since counters were last (0,0) after reset

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
    pos += n;
  endtask

  task automatic adv_to(input int p);
    adv(p - pos);
  endtask

  // One clock of reset, check reset values on both instances, then release.
  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    @(negedge clk);
    check({tag, "_raddr1"}, bus1.raddr, 0);
    check({tag, "_rgb1"},   bus1.rgb,   0);
    check({tag, "_de1"},    bus1.de,    0);
    check({tag, "_fs1"},    bus1.frame_start, 0);
    check({tag, "_hs1"},    bus1.hs,    0);
    check({tag, "_vs1"},    bus1.vs,    0);
    check({tag, "_de2"},    bus2.de,    0);
    check({tag, "_hs2"},    bus2.hs,    0);
    check({tag, "_vs2"},    bus2.vs,    0);
    rst = 1'b0;
    pos = 0;
  endtask

  int hs_prev, hs_rise, hs_first, hs_rises, hs_bad;
  int vs_prev, vs_rise, vs_first, vs_rises, vs_bad;
  int de_prev, de_rise, de_first, de_runs, de_bad;
  int hs2_prev, hs2_first, de2_prev, de2_first;
  int rgb_bad1, rgb_bad2;

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 12'(i);

    // ---- Reset state and release ----
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("init_raddr", bus1.raddr, 0);
    check("init_rgb",   bus1.rgb,   0);
    check("init_de",    bus1.de,    0);
    check("init_fs",    bus1.frame_start, 0);
    check("init_hs",    bus1.hs,    0);
    check("init_vs",    bus1.vs,    0);
    rst = 1'b0;
    pos = 0;

    // ---- First pixel alignment, mem[i] = i ----
    check("fs1_t0", bus1.frame_start, 0);
    adv_to(2);
    check("fs1_t2", bus1.frame_start, 0);
    check("de1_t2", bus1.de, 0);
    adv_to(3);
    check("fs1_t3",  bus1.frame_start, 1);
    check("de1_t3",  bus1.de, 1);
    check("rgb1_t3", bus1.rgb, 12'h000);
    check("fs2_t3",  bus2.frame_start, 0);
    adv_to(4);
    check("fs1_t4", bus1.frame_start, 0);
    check("fs2_t4", bus2.frame_start, 1);
    check("de2_t4", bus2.de, 1);
    adv_to(6);
    check("rgb1_x3", bus1.rgb, 12'h000);
    adv_to(7);
    check("rgb1_x4", bus1.rgb, 12'h001);
    check("rgb2_x3", bus2.rgb, 12'h000);
    adv_to(8);
    check("rgb2_x4", bus2.rgb, 12'h001);

    // ---- Address generation at line edges ----
    adv_to(800);
    check("raddr_799_0", bus1.raddr, 199);
    adv_to(801);
    check("raddr_800_0", bus1.raddr, 0);
    adv_to(802);
    check("rgb1_x799", bus1.rgb, 12'h0C7);
    check("de1_x799",  bus1.de, 1);
    adv_to(803);
    check("de1_x800",  bus1.de, 0);
    adv_to(9 * H_TOT + 6);
    check("raddr_5_9", bus1.raddr, 401);
    adv_to(9 * H_TOT + 8);
    check("rgb1_5_9", bus1.rgb, 12'h191);
    adv_to(9 * H_TOT + 9);
    check("rgb2_5_9", bus2.rgb, 12'h191);
    adv_to(9 * H_TOT + 800);
    check("raddr_799_9", bus1.raddr, 599);
    adv_to(9 * H_TOT + 801);
    check("raddr_800_9", bus1.raddr, 0);
    adv_to(10 * H_TOT + 6);
    check("raddr_5_10", bus1.raddr, 0);
    adv_to(10 * H_TOT + 8);
    check("de1_5_10", bus1.de, 0);

    // ---- Two full frames with mem = FFF: sync shapes, de runs, blanking ----
    for (int i = 0; i < 32768; i++) mem[i] = 12'hFFF;
    pulse_reset("rst_b");
    hs_prev = 0; hs_rise = -1; hs_first = -1; hs_rises = 0; hs_bad = 0;
    vs_prev = 0; vs_rise = -1; vs_first = -1; vs_rises = 0; vs_bad = 0;
    de_prev = 0; de_rise = -1; de_first = -1; de_runs  = 0; de_bad = 0;
    hs2_prev = 0; hs2_first = -1; de2_prev = 0; de2_first = -1;
    rgb_bad1 = 0; rgb_bad2 = 0;
    for (int p = 0; p < 2 * FRAME; p++) begin
      if (bus1.hs && hs_prev == 0) begin
        if (hs_rise >= 0 && pos - hs_rise != H_TOT) hs_bad++;
        if (hs_first < 0) hs_first = pos;
        hs_rise = pos;
        hs_rises++;
      end
      if (!bus1.hs && hs_prev == 1 && pos - hs_rise != 120) hs_bad++;
      if (bus1.vs && vs_prev == 0) begin
        if (vs_rise >= 0 && pos - vs_rise != FRAME) vs_bad++;
        if (vs_first < 0) vs_first = pos;
        vs_rise = pos;
        vs_rises++;
      end
      if (!bus1.vs && vs_prev == 1 && pos - vs_rise != V_SYNC * H_TOT) vs_bad++;
      if (bus1.de && de_prev == 0) begin
        if (de_first < 0) de_first = pos;
        de_rise = pos;
      end
      if (!bus1.de && de_prev == 1) begin
        if (pos - de_rise != 800) de_bad++;
        de_runs++;
      end
      if (bus2.hs && hs2_prev == 0 && hs2_first < 0) hs2_first = pos;
      if (bus2.de && de2_prev == 0 && de2_first < 0) de2_first = pos;
      if (bus1.rgb !== (bus1.de === 1'b1 ? 12'hFFF : 12'h000)) rgb_bad1++;
      if (bus2.rgb !== (bus2.de === 1'b1 ? 12'hFFF : 12'h000)) rgb_bad2++;
      hs_prev  = int'(bus1.hs);
      vs_prev  = int'(bus1.vs);
      de_prev  = int'(bus1.de);
      hs2_prev = int'(bus2.hs);
      de2_prev = int'(bus2.de);
      adv(1);
    end
    check("hs_first",   hs_first, 859);
    check("hs_rises",   hs_rises, 2 * V_TOT);
    check("hs_shape",   hs_bad,   0);
    check("vs_first",   vs_first, 11 * H_TOT + 3);
    check("vs_rises",   vs_rises, 2);
    check("vs_shape",   vs_bad,   0);
    check("de_first",   de_first, 3);
    check("de_runs",    de_runs,  2 * V_VIS);
    check("de_len",     de_bad,   0);
    check("rgb1_blank", rgb_bad1, 0);
    check("rgb2_blank", rgb_bad2, 0);
    check("hs2_first",  hs2_first, 860);
    check("de2_first",  de2_first, 4);

    // ---- Mid-frame reset at (400,5), then during hs, then during vs ----
    adv_to(2 * FRAME + 5 * H_TOT + 400);
    check("pre_rst_de1", bus1.de, 1);
    pulse_reset("rst_mid");
    adv_to(2);
    check("mid_fs1_t2", bus1.frame_start, 0);
    adv_to(3);
    check("mid_fs1_t3", bus1.frame_start, 1);
    adv_to(4);
    check("mid_fs2_t4", bus2.frame_start, 1);
    adv_to(858);
    check("mid_hs_858", bus1.hs, 0);
    adv_to(859);
    check("mid_hs_859", bus1.hs, 1);
    adv_to(900);
    check("pre_rst_hs1", bus1.hs, 1);
    pulse_reset("rst_hs");
    adv_to(858);
    check("hs_after_858", bus1.hs, 0);
    adv_to(859);
    check("hs_after_859", bus1.hs, 1);
    adv_to(978);
    check("hs_after_978", bus1.hs, 1);
    adv_to(979);
    check("hs_after_979", bus1.hs, 0);
    adv_to(859 + H_TOT - 1);
    check("hs_per_m1", bus1.hs, 0);
    adv_to(859 + H_TOT);
    check("hs_per", bus1.hs, 1);
    adv_to(11 * H_TOT + 2);
    check("vs_pre", bus1.vs, 0);
    adv_to(11 * H_TOT + 3);
    check("vs_rise1", bus1.vs, 1);
    check("vs2_pre",  bus2.vs, 0);
    adv_to(11 * H_TOT + 4);
    check("vs_rise2", bus2.vs, 1);
    adv_to(11 * H_TOT + 20);
    pulse_reset("rst_vs");
    adv_to(3);
    check("post_vs_fs1", bus1.frame_start, 1);
    check("post_vs_vs1", bus1.vs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
